rr_onehot_arbiter: RTL and testbench

//  Round-robin arbiter sharing one resource among 8 requesters.

---
 rtl/rr_onehot_arbiter.sv | 109 ++++++++++
 tb/tb_rr_onehot_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter for 8 requesters with registered index and one-hot grant.
// Grants are held until done, requester withdrawal, or a hold-time limit.
module rr_onehot_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam bit HAS_LIMIT = (MAX_HOLD != 0);
    localparam int LAST_I = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
    localparam logic [CNT_W-1:0] HOLD_LAST = LAST_I[CNT_W-1:0];

    generate
        if ((1 << CNT_W) <= MAX_HOLD) begin : g_bad_cnt_w
            $error("CNT_W too narrow for MAX_HOLD");
        end
    endgenerate

    state_t           state;
    logic [2:0]       ptr;
    logic [CNT_W-1:0] hold_cnt;

    logic [2:0] cand;
    logic [2:0] pick_idx;
    logic       pick_ok;

    logic hit_done;
    logic hit_wd;
    logic hit_lim;
    logic release_now;

    // Rotating priority search starting at ptr; the lowest offset wins.
    always_comb begin
        pick_ok  = 1'b0;
        pick_idx = ptr;
        cand     = ptr;
        for (int i = 7; i >= 0; i--) begin
            cand = ptr + 3'(i);
            if (req[cand]) begin
                pick_ok  = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Release causes while a grant is held; limit only counts as a timeout alone.
    always_comb begin
        hit_done    = done;
        hit_wd      = ~req[gnt_idx];
        hit_lim     = HAS_LIMIT && (hold_cnt == HOLD_LAST);
        release_now = hit_done | hit_wd | hit_lim;
    end

    // Single FSM register block; every output is registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            hold_cnt  <= '0;
            gnt       <= 8'd0;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    if (pick_ok) begin
                        state     <= GRANT;
                        gnt_idx   <= pick_idx;
                        gnt       <= 8'd1 << pick_idx;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state     <= IDLE;
                        gnt       <= 8'd0;
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_idx + 3'd1;
                        hold_cnt  <= '0;
                        timeout   <= hit_lim & ~hit_done & ~hit_wd;
                    end else begin
                        hold_cnt  <= hold_cnt + 1'b1;
                        timeout   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Scoreboard bench for rr_onehot_arbiter.
// A behavioural model queues expected outputs per cycle; samples pop and compare.
module tb_rr_onehot_arbiter;

    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       to;
    } exp_t;

    exp_t sb[$];
    int   seen[$];
    int   n_run = 0;
    int   n_fail = 0;

    int   m_st, m_ptr, m_cnt, m_idx;
    exp_t m_out;
    logic prev_valid = 1'b0;

    rr_onehot_arbiter #(
        .MAX_HOLD(MAX_HOLD),
        .CNT_W(5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .done(done),
        .gnt(gnt),
        .gnt_idx(gnt_idx),
        .gnt_valid(gnt_valid),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input logic [7:0] r, input logic d, input logic rs);
        bit found;
        bit w, t;
        if (!rs) begin
            m_st = 0; m_ptr = 0; m_cnt = 0; m_idx = 0;
            m_out = '0;
        end else if (m_st == 0) begin
            m_out.to = 1'b0;
            found = 0;
            for (int k = 0; k < 8; k++) begin
                if (!found && r[(m_ptr + k) % 8]) begin
                    found = 1;
                    m_idx = (m_ptr + k) % 8;
                end
            end
            if (found) begin
                m_st = 1;
                m_cnt = 0;
                m_out.gnt = 8'd1 << m_idx;
                m_out.idx = m_idx[2:0];
                m_out.valid = 1'b1;
            end
        end else begin
            w = !r[m_idx];
            t = (m_cnt == MAX_HOLD - 1);
            if (d || w || t) begin
                m_st = 0;
                m_ptr = (m_idx + 1) % 8;
                m_out.gnt = 8'd0;
                m_out.valid = 1'b0;
                m_out.to = t && !d && !w;
            end else begin
                m_cnt++;
                m_out.to = 1'b0;
            end
        end
    endtask

    task automatic step(input logic [7:0] r, input logic d, input logic rs);
        exp_t e;
        req = r;
        done = d;
        rst_n = rs;
        model(r, d, rs);
        sb.push_back(m_out);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("gnt", gnt, e.gnt);
        chk("gnt_idx", gnt_idx, e.idx);
        chk("gnt_valid", gnt_valid, e.valid);
        chk("timeout", timeout, e.to);
        if (gnt_valid && !prev_valid) seen.push_back(int'(gnt_idx));
        prev_valid = gnt_valid;
    endtask

    int exp_seq[8] = '{1, 2, 3, 4, 5, 6, 7, 0};
    int hi_cnt;
    int to_cnt;

    initial begin
        // 1: reset with all requesting, then first grant goes to 0
        for (int i = 0; i < 3; i++) begin
            step(8'hFF, 1'b0, 1'b0);
            chk("t1_rst_gnt", gnt, 8'h00);
        end
        step(8'hFF, 1'b0, 1'b1);
        chk("t1_first_gnt", gnt, 8'h01);
        chk("t1_first_idx", gnt_idx, 3'd0);

        // 2: full rotation with done every grant cycle
        seen.delete();
        for (int i = 0; i < 16; i++) step(8'hFF, 1'b1, 1'b1);
        chk("t2_nseen", seen.size(), 8);
        for (int i = 0; i < 8 && i < seen.size(); i++)
            chk("t2_seq", seen[i], exp_seq[i]);

        // 3: ptr=5 then wrap path
        step(8'h00, 1'b0, 1'b0);
        step(8'h10, 1'b0, 1'b1);
        step(8'h10, 1'b1, 1'b1);
        step(8'h90, 1'b0, 1'b1);
        chk("t3_idx7", gnt_idx, 3'd7);
        step(8'h90, 1'b1, 1'b1);
        step(8'h90, 1'b0, 1'b1);
        chk("t3_idx4", gnt_idx, 3'd4);
        step(8'h90, 1'b1, 1'b1);

        // 4: hold limit forces release after 16 cycles
        step(8'h00, 1'b0, 1'b0);
        hi_cnt = 0;
        to_cnt = 0;
        for (int i = 0; i < 18; i++) begin
            step(8'h04, 1'b0, 1'b1);
            if (gnt == 8'h04 && i < 16) hi_cnt++;
            if (timeout) to_cnt++;
        end
        chk("t4_hold", hi_cnt, 16);
        chk("t4_to_pulses", to_cnt, 1);
        chk("t4_regrant", gnt, 8'h04);
        step(8'h00, 1'b0, 1'b1);

        // 5: withdraw on 4th grant cycle; done coincident with limit
        step(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(8'h08, 1'b0, 1'b1);
        chk("t5_held", gnt, 8'h08);
        step(8'h00, 1'b0, 1'b1);
        chk("t5_wd_gnt", gnt, 8'h00);
        chk("t5_wd_to", timeout, 1'b0);
        step(8'h08, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) step(8'h08, 1'b0, 1'b1);
        chk("t5_still", gnt, 8'h08);
        step(8'h08, 1'b1, 1'b1);
        chk("t5_dn_gnt", gnt, 8'h00);
        chk("t5_dn_to", timeout, 1'b0);
        step(8'h00, 1'b0, 1'b1);

        // 6: reset mid-grant, ptr returns to 0
        step(8'h00, 1'b0, 1'b0);
        step(8'h40, 1'b0, 1'b1);
        step(8'h40, 1'b0, 1'b1);
        chk("t6_g6", gnt_idx, 3'd6);
        step(8'h40, 1'b0, 1'b0);
        chk("t6_rst_gnt", gnt, 8'h00);
        chk("t6_rst_v", gnt_valid, 1'b0);
        step(8'hC0, 1'b0, 1'b1);
        chk("t6_after", gnt_idx, 3'd6);
        chk("t6_after_g", gnt, 8'h40);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(8'($urandom) & 8'($urandom),
                 ($urandom_range(3) == 0),
                 ($urandom_range(60) != 0));
            chk("onehot", $countones(gnt) <= 1, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
